controller_responder_m: RTL
===========================

# controller_responder_m

Device-side end of the serial controller protocol: emulates one game controller on the latch/clock/data wires driven by the console's controller interface. Raw button switches are synchronized and debounced. The debounced state is parallel-loaded on latch and shifted out one bit per host clock pulse on an active-low data line. Used in bench harnesses and in the FPGA-hosted virtual-controller path.

## Interface
- DEBOUNCE_CYCLES, default 12588: consecutive clk cycles a raw button must hold a new level before the debounced state follows (about 1 ms at 12.5875 MHz); legal range 1..65535.
- MSB_FIRST, default 1: 1 shifts buttons_debounced[7] first, 0 shifts bit [0] first.
- clk  in  1  single block clock; all state is on its rising edge.
- rst_B  in  1  asynchronous, active-low reset.
- buttons_raw  in  8  raw switches, 1 = pressed, asynchronous to clk.
- controller_latch  in  1  host latch line, asynchronous; high = parallel load.
- controller_clk  in  1  host shift clock line, asynchronous; rising edge = advance one bit.
- controller_data_out_B  out  1  serial data to the host, active-low (0 = pressed).
- buttons_debounced  out  8  current debounced button state, 1 = pressed.
- bit_count  out  4  bits already shifted since the last load, 0..8.
- frame_done  out  1  one-cycle pulse when the 8th bit has been shifted.
- overrun  out  1  one-cycle pulse on a shift edge with bit_count == 8.

## Operation
- Synchronizers: two-flop synchronizers on buttons_raw, controller_latch and controller_clk.
- A third flop on the latch and clock paths provides edge detection.
- Debounce, per button:
  - 16-bit counter cnt.
  - If the synced raw level equals the debounced level, cnt = 0.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1, the debounced bit takes the raw level and cnt = 0.
- Shift register shreg[7:0], with bit order remapped per MSB_FIRST so the head bit is shreg[7].
- controller_data_out_B = ~shreg[7], driven directly from the flop with no extra logic stage beyond the inverter.
- Load: every cycle that synced latch is 1, shreg <= ordered buttons_debounced and bit_count <= 0. A load is therefore transparent while latch is held, and debounce changes during a held latch propagate.
- Shift: on a synced controller_clk rising edge while synced latch is 0:
  - If bit_count < 8: shreg <= {shreg[6:0],1'b0} and bit_count++.
  - If bit_count becomes 8, frame_done pulses.
  - If bit_count == 8: no state change and overrun pulses. The data line stays 1 (released).
- Simultaneous events:
  - A clock edge while latch is high is ignored; the load wins and no overrun is raised.
  - A latch falling edge has no effect.
- Reset (rst_B = 0, at any time including mid-frame): all flops clear immediately.
  - shreg = 0, bit_count = 8, buttons_debounced = 0, all debounce counters = 0.
  - Synchronizers = 0, frame_done = 0, overrun = 0.
  - controller_data_out_B = 1.
  - After release, the first transfer requires a new latch.

## Timing
- Host edge to controller_data_out_B / bit_count change: the 3rd rising clk edge after the input edge, assuming setup to clk is met (two sync flops plus the register update).
- Host protocol requirement: latch high ≥ 4 clk; controller_clk high and low phases ≥ 4 clk each. Shorter pulses may be lost; this is not detected.
- buttons_raw change to buttons_debounced change: 2 + DEBOUNCE_CYCLES clk edges if the raw level is stable throughout. Any reversion before that point restarts the count.
- frame_done and overrun are high for exactly one clk, in the same cycle that bit_count is (or would be) updated.
- Bit sequence for MSB_FIRST=1: after latch, the line presents bit 7. Each shift edge exposes the next bit (6..0). After the 8th edge the line reads 1.

## Test plan
- Reset: hold rst_B=0 with random inputs → controller_data_out_B=1, bit_count=8, buttons_debounced=0, no pulses. Deassert, then issue 3 clk pulses with no latch → 3 overrun pulses and no data change.
- Debounce with DEBOUNCE_CYCLES=4:
  - buttons_raw[0] glitches high for 3 clk → buttons_debounced stays 0.
  - Held high → buttons_debounced = 8'h01 exactly 6 clk edges after the change.
- Full frame, MSB_FIRST=1: debounced state 8'b1000_1001, latch, then 8 clock pulses → line samples before each edge are 0,1,1,1,0,1,1,0. frame_done pulses once after edge 8 with bit_count=8, and the line is then 1.
- MSB_FIRST=0 with 8'b1000_1001 → line samples 0,1,1,0,1,1,1,0.
- Overrun: 9th clock pulse → overrun pulses once, bit_count stays 8, line stays 1.
- Mid-frame events:
  - Latch after 3 shifts → bit_count=0 and the line shows bit 7 again.
  - Clock edge during latch high → ignored, no overrun.
  - rst_B pulse after 5 shifts → bit_count=8 and line=1 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/controller_responder_m.sv
// controller_responder_m
// Device-side end of the latch/clock/data controller protocol. Raw button
// switches are synchronized and debounced; the debounced byte is loaded into a
// shift register while the host latch is high and shifted out one bit per host
// clock rising edge on an active-low data line.

module controller_responder_m #(
   parameter int unsigned DEBOUNCE_CYCLES = 12588,  // legal 1..65535
   parameter bit          MSB_FIRST       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_B,
   input  logic [7:0] buttons_raw,
   input  logic       controller_latch,
   input  logic       controller_clk,
   output logic       controller_data_out_B,
   output logic [7:0] buttons_debounced,
   output logic [3:0] bit_count,
   output logic       frame_done,
   output logic       overrun
);

   // Last count value before the debounced bit is allowed to follow.
   localparam logic [15:0] CNT_LAST   = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]  FRAME_BITS = 4'd8;

   // ------------------------------------------------------------------------
   // Synchronizers and edge detection
   // ------------------------------------------------------------------------
   logic [7:0] btn_s1_q, btn_s2_q;
   logic       latch_s1_q, latch_s2_q, latch_s3_q;
   logic       hclk_s1_q, hclk_s2_q, hclk_s3_q;
   logic       hclk_rise;

   // Two-flop synchronizers on all host/switch inputs; third flop for edges.
   always_ff @(posedge clk or negedge rst_B) begin
      if (!rst_B) begin
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         latch_s1_q <= 1'b0;
         latch_s2_q <= 1'b0;
         latch_s3_q <= 1'b0;
         hclk_s1_q  <= 1'b0;
         hclk_s2_q  <= 1'b0;
         hclk_s3_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the value from
         // before this edge, which is what makes the chain a real pipeline.
         btn_s1_q   <= buttons_raw;
         btn_s2_q   <= btn_s1_q;
         latch_s1_q <= controller_latch;
         latch_s2_q <= latch_s1_q;
         latch_s3_q <= latch_s2_q;
         hclk_s1_q  <= controller_clk;
         hclk_s2_q  <= hclk_s1_q;
         hclk_s3_q  <= hclk_s2_q;
      end
   end

   assign hclk_rise = hclk_s2_q & ~hclk_s3_q;

   // The latch falling edge carries no meaning, so only its level is used;
   // the third latch flop exists purely to keep both host paths identical.
   logic latch_unused;
   assign latch_unused = latch_s3_q;

   // ------------------------------------------------------------------------
   // Debounce: one counter per button, counting cycles of disagreement
   // ------------------------------------------------------------------------
   logic [7:0][15:0] cnt_q, cnt_d;
   logic [7:0]       deb_q, deb_d;

   // Count while the synced level disagrees; adopt it after the full interval.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      deb_d = deb_q;
      cnt_d = '0;
      for (int i = 0; i < 8; i++) begin
         if (btn_s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = btn_s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or negedge rst_B) begin
      if (!rst_B) begin
         // NOTE: the counter array is small and its start value matters for
         // the debounce interval, so it is reset like any other state.
         cnt_q <= '0;
         deb_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   // ------------------------------------------------------------------------
   // Shift register: load on latch level, advance on host clock rising edge
   // ------------------------------------------------------------------------
   logic [7:0] shreg_q, shreg_d;
   logic [3:0] bit_count_q, bit_count_d;
   logic       frame_done_q, frame_done_d;
   logic       overrun_q, overrun_d;

   // Place the first bit to be sent at shreg[7] regardless of bit order.
   function automatic logic [7:0] order_bits(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (!MSB_FIRST) begin
         for (int i = 0; i < 8; i++) begin
            r[7 - i] = b[i];
         end
      end
      return r;
   endfunction

   // Latch level wins over any clock edge; shifts past the 8th bit only flag.
   always_comb begin
      shreg_d      = shreg_q;
      bit_count_d  = bit_count_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      if (latch_s2_q) begin
         shreg_d     = order_bits(deb_q);
         bit_count_d = '0;
      end else if (hclk_rise) begin
         if (bit_count_q < FRAME_BITS) begin
            shreg_d      = {shreg_q[6:0], 1'b0};
            bit_count_d  = bit_count_q + 4'd1;
            frame_done_d = (bit_count_q == FRAME_BITS - 4'd1);
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Shift state and pulse registers; reset leaves the line released.
   always_ff @(posedge clk or negedge rst_B) begin
      if (!rst_B) begin
         shreg_q      <= '0;
         bit_count_q  <= FRAME_BITS;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         bit_count_q  <= bit_count_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Data line comes straight off the head flop through a single inverter.
   assign controller_data_out_B = ~shreg_q[7];
   assign buttons_debounced     = deb_q;
   assign bit_count             = bit_count_q;
   assign frame_done            = frame_done_q;
   assign overrun               = overrun_q;

endmodule
